// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of a single-port, 1-cycle-latency data RAM.
// M0 is the core LSU port and M1 is the debug memory port, which can lock the RAM for itself.
module ram_arbiter #(
  parameter int DEPTH  = 8192,
  parameter int ADDR_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic                         m0_req,
  input  logic                         m0_we,
  input  logic [ADDR_W-1:0]            m0_addr,
  input  logic [31:0]                  m0_wdata,
  input  logic [3:0]                   m0_be,
  output logic                         m0_gnt,
  output logic                         m0_rvalid,
  output logic [31:0]                  m0_rdata,
  output logic                         m0_err,

  input  logic                         m1_req,
  input  logic                         m1_we,
  input  logic [ADDR_W-1:0]            m1_addr,
  input  logic [31:0]                  m1_wdata,
  input  logic [3:0]                   m1_be,
  input  logic                         m1_lock,
  output logic                         m1_gnt,
  output logic                         m1_rvalid,
  output logic [31:0]                  m1_rdata,
  output logic                         m1_err,

  output logic                         ram_en,
  output logic [3:0]                   ram_we,
  output logic [$clog2(DEPTH/4)-1:0]   ram_addr,
  output logic [31:0]                  ram_wdata,
  input  logic [31:0]                  ram_rdata
);

  localparam int WORDS  = DEPTH / 4;
  localparam int RAM_AW = $clog2(WORDS);
  localparam logic [ADDR_W-3:0] WORD_LIMIT = (ADDR_W-2)'(WORDS);

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_last;
  logic                r_rvalid;
  logic                r_who;
  logic                r_err;
  logic                r_read;

  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_anyGnt;
  logic                w_we;
  logic [ADDR_W-1:0]   w_addr;
  logic [ADDR_W-3:0]   w_wordIdx;
  logic [31:0]         w_wdata;
  logic [3:0]          w_be;
  logic                w_inRange;
  logic [31:0]         w_rdata;
  logic                w_unused;

  // r_last = 1 means M1 had the most recent grant, so M0 wins the next conflict.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst) begin
      if (r_state == LOCKED) begin
        w_gnt1 = m1_req;
      end else if (m0_req && m1_req) begin
        w_gnt0 = r_last;
        w_gnt1 = !r_last;
      end else begin
        w_gnt0 = m0_req;
        w_gnt1 = m1_req;
      end
    end
  end

  assign w_anyGnt  = w_gnt0 | w_gnt1;
  assign w_we      = w_gnt1 ? m1_we    : m0_we;
  assign w_addr    = w_gnt1 ? m1_addr  : m0_addr;
  assign w_wdata   = w_gnt1 ? m1_wdata : m0_wdata;
  assign w_be      = w_gnt1 ? m1_be    : m0_be;
  assign w_wordIdx = w_addr[ADDR_W-1:2];
  assign w_inRange = (w_wordIdx < WORD_LIMIT);
  assign w_unused  = ^w_addr[1:0];

  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  // Out-of-range grants are still acknowledged but never touch the RAM.
  assign ram_en    = w_anyGnt && w_inRange;
  assign ram_we    = (ram_en && w_we) ? w_be : 4'b0000;
  assign ram_addr  = w_wordIdx[RAM_AW-1:0];
  assign ram_wdata = w_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ARB;
      r_last   <= 1'b1;
      r_rvalid <= 1'b0;
      r_who    <= 1'b0;
      r_err    <= 1'b0;
      r_read   <= 1'b0;
    end else begin
      r_rvalid <= w_anyGnt;
      if (w_anyGnt) begin
        r_who  <= w_gnt1;
        r_err  <= !w_inRange;
        r_read <= !w_we;
        r_last <= w_gnt1;
      end
      case (r_state)
        ARB:     if (w_gnt1 && m1_lock) r_state <= LOCKED;
        LOCKED:  if (!m1_lock)          r_state <= ARB;
        default:                        r_state <= ARB;
      endcase
    end
  end

  // Only in-range reads return RAM data; writes and errors respond with zero.
  assign w_rdata   = (r_rvalid && r_read && !r_err) ? ram_rdata : 32'h0;

  assign m0_rvalid = r_rvalid && !r_who;
  assign m0_rdata  = m0_rvalid ? w_rdata : 32'h0;
  assign m0_err    = m0_rvalid && r_err;

  assign m1_rvalid = r_rvalid && r_who;
  assign m1_rdata  = m1_rvalid ? w_rdata : 32'h0;
  assign m1_err    = m1_rvalid && r_err;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a behavioural RAM sits on the ram_* port and
// expected responses are queued at grant time and compared one cycle later.
module tb_ram_arbiter;

  localparam int DEPTH = 8192;
  localparam int WORDS = DEPTH / 4;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_be;
  logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_be;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [10:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic        pokeEn;
  logic [10:0] pokeAddr;
  logic [31:0] pokeData;
  logic [31:0] ramMem [0:WORDS-1];
  logic [31:0] refMem [0:WORDS-1];

  typedef struct {
    int          m;
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t sbQ[$];
  int   checks;
  int   failures;
  int   cyc;

  ram_arbiter #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_lock(m1_lock),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-lane RAM with 1-cycle read, plus a backdoor port for preloading.
  always @(posedge clk) begin
    if (pokeEn) begin
      ramMem[pokeAddr] <= pokeData;
    end else if (ram_en) begin
      for (int n = 0; n < 4; n++)
        if (ram_we[n]) ramMem[ram_addr][8*n +: 8] <= ram_wdata[8*n +: 8];
      ram_rdata <= ramMem[ram_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input int m, input logic req, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be;
    end
  endtask

  task automatic preload(input int word, input logic [31:0] data);
    pokeEn = 1'b1; pokeAddr = 11'(word); pokeData = data;
    refMem[word] = data;
    @(posedge clk); #1;
    pokeEn = 1'b0;
  endtask

  // Model of the response a granted access must produce one cycle later.
  task automatic pushExpect(input int m, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    int   w;
    w     = int'(addr >> 2);
    e.m   = m;
    e.due = cyc + 1;
    e.err = 1'b0;
    e.data = 32'h0;
    if (addr >= 32'(DEPTH)) begin
      e.err = 1'b1;
    end else if (we) begin
      for (int n = 0; n < 4; n++)
        if (be[n]) refMem[w][8*n +: 8] = wdata[8*n +: 8];
    end else begin
      e.data = refMem[w];
    end
    sbQ.push_back(e);
  endtask

  task automatic checkResponses();
    exp_t e;
    if (sbQ.size() > 0 && sbQ[0].due == cyc) begin
      e = sbQ.pop_front();
      if (e.m == 0) begin
        checkOutput("m0_rvalid", 32'(m0_rvalid), 32'd1);
        checkOutput("m0_rdata", m0_rdata, e.data);
        checkOutput("m0_err", 32'(m0_err), 32'(e.err));
        checkOutput("m1_rvalid idle", 32'(m1_rvalid), 32'd0);
      end else begin
        checkOutput("m1_rvalid", 32'(m1_rvalid), 32'd1);
        checkOutput("m1_rdata", m1_rdata, e.data);
        checkOutput("m1_err", 32'(m1_err), 32'(e.err));
        checkOutput("m0_rvalid idle", 32'(m0_rvalid), 32'd0);
      end
    end else begin
      checkOutput("m0_rvalid idle", 32'(m0_rvalid), 32'd0);
      checkOutput("m1_rvalid idle", 32'(m1_rvalid), 32'd0);
      checkOutput("m0_rdata idle", m0_rdata, 32'h0);
      checkOutput("m1_rdata idle", m1_rdata, 32'h0);
    end
  endtask

  task automatic nextCycle();
    checkResponses();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    m1_lock = 1'b0;
    @(negedge clk);
    nextCycle();
  endtask

  // Reset for one cycle with both requests held, so grant gating is exercised.
  task automatic doReset(input string tag);
    rst = 1'b1;
    sbQ.delete();
    m0_req = 1'b1;
    m1_req = 1'b1;
    @(negedge clk);
    checkOutput({tag, " m0_gnt"},    32'(m0_gnt), 32'd0);
    checkOutput({tag, " m1_gnt"},    32'(m1_gnt), 32'd0);
    checkOutput({tag, " m0_rvalid"}, 32'(m0_rvalid), 32'd0);
    checkOutput({tag, " m1_rvalid"}, 32'(m1_rvalid), 32'd0);
    checkOutput({tag, " m0_rdata"},  m0_rdata, 32'h0);
    checkOutput({tag, " m0_err"},    32'(m0_err), 32'd0);
    checkOutput({tag, " ram_en"},    32'(ram_en), 32'd0);
    checkOutput({tag, " ram_we"},    32'(ram_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m0_req = 1'b0;
    m1_req = 1'b0;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int a0, a1;
    checks = 0; failures = 0; cyc = 0;
    rst = 1'b1; pokeEn = 1'b0; pokeAddr = '0; pokeData = '0;
    m1_lock = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    preload(5, 32'h12345678);
    preload(4, 32'h00000000);
    preload(100, 32'h1000_0064);
    preload(101, 32'h1000_0065);
    preload(102, 32'h2000_0066);
    preload(103, 32'h2000_0067);
    preload(2047, 32'hCAFE_F00D);
    doReset("reset");

    $display("[TB] single core read of word 5");
    applyStimulus(0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("t1 m0_gnt", 32'(m0_gnt), 32'd1);
    checkOutput("t1 m1_gnt", 32'(m1_gnt), 32'd0);
    checkOutput("t1 ram_en", 32'(ram_en), 32'd1);
    checkOutput("t1 ram_addr", 32'(ram_addr), 32'd5);
    checkOutput("t1 ram_we", 32'(ram_we), 32'd0);
    pushExpect(0, 1'b0, 32'h14, 32'h0, 4'h0);
    nextCycle();
    idleCycle();

    $display("[TB] round-robin from reset");
    doReset("reset2");
    a0 = 100; a1 = 102;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'b1, 1'b0, 32'(a0 * 4), 32'h0, 4'h0);
      applyStimulus(1, 1'b1, 1'b0, 32'(a1 * 4), 32'h0, 4'h0);
      @(negedge clk);
      checkOutput("t2 m0_gnt", 32'(m0_gnt), 32'((i % 2) == 0));
      checkOutput("t2 m1_gnt", 32'(m1_gnt), 32'((i % 2) == 1));
      if ((i % 2) == 0) begin
        checkOutput("t2 ram_addr", 32'(ram_addr), 32'(a0));
        pushExpect(0, 1'b0, 32'(a0 * 4), 32'h0, 4'h0);
        a0++;
      end else begin
        checkOutput("t2 ram_addr", 32'(ram_addr), 32'(a1));
        pushExpect(1, 1'b0, 32'(a1 * 4), 32'h0, 4'h0);
        a1++;
      end
      nextCycle();
    end
    idleCycle();

    $display("[TB] partial write then read back");
    applyStimulus(1, 1'b1, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0011);
    @(negedge clk);
    checkOutput("t3 m1_gnt", 32'(m1_gnt), 32'd1);
    checkOutput("t3 ram_we", 32'(ram_we), 32'b0011);
    checkOutput("t3 ram_wdata", ram_wdata, 32'hAABBCCDD);
    checkOutput("t3 ram_addr", 32'(ram_addr), 32'd4);
    pushExpect(1, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0011);
    nextCycle();
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("t3 m0_gnt", 32'(m0_gnt), 32'd1);
    pushExpect(0, 1'b0, 32'h10, 32'h0, 4'h0);
    nextCycle();
    idleCycle();

    $display("[TB] debug lock blocks the core");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
      applyStimulus(1, i < 4, 1'b0, 32'((100 + i) * 4), 32'h0, 4'h0);
      m1_lock = (i < 3);
      @(negedge clk);
      checkOutput("t4 m0_gnt", 32'(m0_gnt), 32'(i == 4));
      checkOutput("t4 m1_gnt", 32'(m1_gnt), 32'(i < 4));
      if (i < 4) pushExpect(1, 1'b0, 32'((100 + i) * 4), 32'h0, 4'h0);
      else       pushExpect(0, 1'b0, 32'h14, 32'h0, 4'h0);
      nextCycle();
    end
    idleCycle();

    $display("[TB] range boundaries and be=0 write");
    applyStimulus(0, 1'b1, 1'b0, 32'd8192, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("t5 oor m0_gnt", 32'(m0_gnt), 32'd1);
    checkOutput("t5 oor ram_en", 32'(ram_en), 32'd0);
    pushExpect(0, 1'b0, 32'd8192, 32'h0, 4'h0);
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 32'd8188, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("t5 top ram_en", 32'(ram_en), 32'd1);
    checkOutput("t5 top ram_addr", 32'(ram_addr), 32'd2047);
    pushExpect(0, 1'b0, 32'd8188, 32'h0, 4'h0);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyStimulus(1, 1'b1, 1'b1, 32'h2000_0000, 32'h5555_AAAA, 4'hF);
    @(negedge clk);
    checkOutput("t5 oor wr m1_gnt", 32'(m1_gnt), 32'd1);
    checkOutput("t5 oor wr ram_en", 32'(ram_en), 32'd0);
    checkOutput("t5 oor wr ram_we", 32'(ram_we), 32'd0);
    pushExpect(1, 1'b1, 32'h2000_0000, 32'h5555_AAAA, 4'hF);
    nextCycle();
    applyStimulus(1, 1'b1, 1'b1, 32'h14, 32'hFFFF_FFFF, 4'h0);
    @(negedge clk);
    checkOutput("t5 be0 ram_en", 32'(ram_en), 32'd1);
    checkOutput("t5 be0 ram_we", 32'(ram_we), 32'd0);
    pushExpect(1, 1'b1, 32'h14, 32'hFFFF_FFFF, 4'h0);
    nextCycle();
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyStimulus(0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
    @(negedge clk);
    pushExpect(0, 1'b0, 32'h14, 32'h0, 4'h0);
    nextCycle();
    idleCycle();

    $display("[TB] reset drops a pending response");
    applyStimulus(0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("t6 m0_gnt", 32'(m0_gnt), 32'd1);
    pushExpect(0, 1'b0, 32'h14, 32'h0, 4'h0);
    nextCycle();
    doReset("t6 reset");
    applyStimulus(0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("t6 conflict m0_gnt", 32'(m0_gnt), 32'd1);
    checkOutput("t6 conflict m1_gnt", 32'(m1_gnt), 32'd0);
    pushExpect(0, 1'b0, 32'h14, 32'h0, 4'h0);
    nextCycle();
    idleCycle();

    $display("[TB] reset while locked");
    applyStimulus(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    m1_lock = 1'b1;
    @(negedge clk);
    checkOutput("t7 m1_gnt", 32'(m1_gnt), 32'd1);
    pushExpect(1, 1'b0, 32'h10, 32'h0, 4'h0);
    nextCycle();
    doReset("t7 reset");
    m1_lock = 1'b0;
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyStimulus(0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("t7 m0_gnt after reset", 32'(m0_gnt), 32'd1);
    pushExpect(0, 1'b0, 32'h14, 32'h0, 4'h0);
    nextCycle();
    idleCycle();

    checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
